// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - integer ALU with valid/ready handshake and iterative MUL/DIVU/REMU
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_XOR = 5'd4, OP_NOT = 5'd5, OP_SLL = 5'd6, OP_SRL = 5'd7,
                           OP_SRA = 5'd8, OP_SLT = 5'd9, OP_SLTU = 5'd10, OP_MUL = 5'd11,
                           OP_DIVU = 5'd12, OP_REMU = 5'd13;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q;
    logic [1:0]        kind_q;
    logic [WIDTH-1:0]  x_q, y_q, z_q;
    logic [WIDTH-1:0]  out_q;
    logic              zero_q, carry_q, ovf_q, err_q;

    logic              accept, retire, is_iter, last;
    logic [WIDTH-1:0]  sc_res;
    logic              sc_carry, sc_ovf, sc_err;
    logic [WIDTH:0]    sum, diff;
    logic [SW-1:0]     shamt;
    logic [WIDTH-1:0]  x_step, y_step, z_step, final_res;
    logic [WIDTH:0]    shifted, trial;

    assign accept  = in_valid & in_ready;
    assign retire  = enable & out_valid & out_ready;
    assign is_iter = MULDIV && (opcode == OP_MUL || opcode == OP_DIVU || opcode == OP_REMU)
                     && (b != '0);
    assign last    = (cnt_q == SW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_IDLE: if (accept) state_d = is_iter ? S_CALC : S_DONE;
                S_CALC: if (last) state_d = S_DONE;
                S_DONE: begin
                    if (accept)      state_d = is_iter ? S_CALC : S_DONE;
                    else if (retire) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == S_DONE);
        in_ready  = enable & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    end

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SW-1:0];

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $signed(a) >>> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // Only b==0 reaches here when MULDIV is set; nonzero b goes iterative.
            OP_MUL:  sc_err = !MULDIV;
            OP_DIVU: begin
                sc_res = MULDIV ? '1 : '0;
                sc_err = 1'b1;
            end
            OP_REMU: begin
                sc_res = MULDIV ? a : '0;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // kind_q holds opcode[1:0]: 2'b11 MUL, 2'b00 DIVU, 2'b01 REMU.
    assign shifted = {x_q, z_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, y_q};

    always_comb begin
        x_step    = x_q;
        y_step    = y_q;
        z_step    = z_q;
        final_res = '0;
        if (kind_q == 2'b11) begin
            x_step    = x_q + (z_q[0] ? y_q : '0);
            y_step    = y_q << 1;
            z_step    = z_q >> 1;
            final_res = x_step;
        end else begin
            if (!trial[WIDTH]) begin
                x_step = trial[WIDTH-1:0];
                z_step = {z_q[WIDTH-2:0], 1'b1};
            end else begin
                x_step = shifted[WIDTH-1:0];
                z_step = {z_q[WIDTH-2:0], 1'b0};
            end
            final_res = (kind_q == 2'b00) ? z_step : x_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            kind_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                cnt_q <= '0;
                if (is_iter) begin
                    kind_q <= opcode[1:0];
                    x_q    <= '0;
                    y_q    <= (opcode == OP_MUL) ? a : b;
                    z_q    <= (opcode == OP_MUL) ? b : a;
                end else begin
                    out_q   <= sc_res;
                    zero_q  <= (sc_res == '0);
                    carry_q <= sc_carry;
                    ovf_q   <= sc_ovf;
                    err_q   <= sc_err;
                end
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + 1'b1;
                x_q   <= x_step;
                y_q   <= y_step;
                z_q   <= z_step;
                if (last) begin
                    out_q   <= final_res;
                    zero_q  <= (final_res == '0);
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign out        = out_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_ovf   = ovf_q;
    assign err        = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed table-driven bench for alu_pipe at WIDTH=32
module tb_alu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, enable, in_valid, out_ready;
    logic         in_ready, out_valid, flag_zero, flag_carry, flag_ovf, err;
    logic [4:0]   opcode;
    logic [W-1:0] a, b, out;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W), .MULDIV(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;   // {zero, carry, ovf, err}
        int           lat;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int  lat;
        int  guard;
        bit  ready_bad;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid  = 1'b1;
        opcode    = v.op;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~v.a;
        b        = ~v.b;
        lat       = 1;
        ready_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d out", idx), 64'(out), 64'(v.res));
        check($sformatf("v%0d flags", idx), 64'({flag_zero, flag_carry, flag_ovf, err}),
              64'(v.flags));
        if (v.lat > 1) check($sformatf("v%0d in_ready in CALC", idx), 64'(ready_bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d retire", idx), 64'(out_valid), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  bad;
        vecs[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010, 1};
        vecs[1]  = '{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 4'b0100, 1};
        vecs[2]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1};
        vecs[3]  = '{5'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010, 1};
        vecs[4]  = '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000, 1};
        vecs[5]  = '{5'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
        vecs[6]  = '{5'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 1};
        vecs[7]  = '{5'd5,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b0000, 1};
        vecs[8]  = '{5'd6,  32'h00000001, 32'd35,       32'h00000008, 4'b0000, 1};
        vecs[9]  = '{5'd7,  32'h80000000, 32'd31,       32'h00000001, 4'b0000, 1};
        vecs[10] = '{5'd8,  32'h80000000, 32'd4,        32'hF8000000, 4'b0000, 1};
        vecs[11] = '{5'd9,  32'hFFFFFFFF, 32'd1,        32'h00000001, 4'b0000, 1};
        vecs[12] = '{5'd10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1000, 1};
        vecs[13] = '{5'd11, 32'd4528,     32'd4500,     32'd20376000, 4'b0000, 33};
        vecs[14] = '{5'd12, 32'd45562,    32'd45500,    32'd1,        4'b0000, 33};
        vecs[15] = '{5'd13, 32'd45562,    32'd45500,    32'd62,       4'b0000, 33};
        vecs[16] = '{5'd12, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b0001, 1};
        vecs[17] = '{5'd13, 32'd9,        32'd0,        32'd9,        4'b0001, 1};
        vecs[18] = '{5'd31, 32'd1,        32'd2,        32'd0,        4'b1001, 1};
        vecs[19] = '{5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        4'b0000, 33};
        vecs[20] = '{5'd12, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 4'b0000, 33};
        vecs[21] = '{5'd13, 32'd100,      32'd7,        32'd2,        4'b0000, 33};
        vecs[22] = '{5'd11, 32'd1234,     32'd0,        32'd0,        4'b1000, 1};
        vecs[23] = '{5'd14, 32'd1,        32'd1,        32'd0,        4'b1001, 1};

        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out", 64'(out), 64'd0);
        check("reset flags", 64'({flag_zero, flag_carry, flag_ovf, err}), 64'd0);

        for (int i = 0; i < 24; i++) run_op(vecs[i], i);

        // Back-to-back single-cycle ops with the consumer always ready.
        out_ready = 1'b1; in_valid = 1'b1;
        opcode = 5'd4; a = 32'hFF00FF00; b = 32'h0F0F0F0F;
        @(posedge clk); #1;
        check("b2b xor", 64'(out), 64'hF00FF00F);
        check("b2b in_ready 1", 64'({out_valid, in_ready}), 64'b11);
        opcode = 5'd8; a = 32'h80000000; b = 32'd4;
        @(posedge clk); #1;
        check("b2b sra", 64'(out), 64'hF8000000);
        check("b2b in_ready 2", 64'({out_valid, in_ready}), 64'b11);
        opcode = 5'd10; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        check("b2b sltu", 64'(out), 64'd1);
        check("b2b in_ready 3", 64'({out_valid, in_ready}), 64'b11);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b drain", 64'(out_valid), 64'd0);

        // Backpressure: result must hold and nothing new is accepted.
        out_ready = 1'b0; in_valid = 1'b1;
        opcode = 5'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        opcode = 5'd1; a = 32'd100; b = 32'd1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out !== 32'd7 || {flag_zero, flag_carry, flag_ovf, err} !== 4'b0000 ||
                in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        check("backpressure stable", 64'(bad), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("backpressure retire", 64'(out_valid), 64'd0);
        run_op(vecs[18], 100);

        // Reset during CALC discards the pending multiply.
        in_valid = 1'b1; opcode = 5'd11; a = 32'd4528; b = 32'd4500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-calc reset", 64'({out_valid, in_ready}), 64'b01);
        check("mid-calc reset out", 64'(out), 64'd0);
        repeat (40) @(posedge clk);
        #1 check("mid-calc discarded", 64'(out_valid), 64'd0);

        // Enable low for 3 cycles during CALC stretches the latency by 3.
        in_valid = 1'b1; opcode = 5'd11; a = 32'd4528; b = 32'd4500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        enable = 1'b0; bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1; lat++;
            if (in_ready) bad = 1'b1;
        end
        enable = 1'b1;
        check("disabled in_ready", 64'(bad), 64'd0);
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("enable gap latency", 64'(lat), 64'd36);
        check("enable gap out", 64'(out), 64'd20376000);

        // Enable low in DONE blocks the retire.
        enable = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("disabled no retire", 64'({out_valid, in_ready}), 64'b10);
        enable = 1'b1;
        @(posedge clk); #1;
        check("enabled retire", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
